// File: rtl/reg_read_stage_if.sv
// Decoded-op bundle between pipeline stages: producer drives op fields and operands, consumer drives stall.
interface reg_read_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned FLEN   = 64,
  parameter int unsigned OP_W   = 64,
  parameter int unsigned TRAP_W = 40
);
  logic              valid;
  logic [OP_W-1:0]   op;
  logic [31:0]       pc;
  logic [31:0]       insn;
  logic [11:0]       csr_addr;
  logic [4:0]        src1;
  logic [4:0]        src2;
  logic [4:0]        dst;
  logic              rd_int1;
  logic              rd_int2;
  logic              rd_fp1;
  logic              rd_fp2;
  logic              wr_int;
  logic              wr_fp;
  logic [TRAP_W-1:0] trap;
  logic [XLEN-1:0]   int_val1;
  logic [XLEN-1:0]   int_val2;
  logic [FLEN-1:0]   fp_val1;
  logic [FLEN-1:0]   fp_val2;
  logic              stall;

  modport master (
    output valid, op, pc, insn, csr_addr, src1, src2, dst,
           rd_int1, rd_int2, rd_fp1, rd_fp2, wr_int, wr_fp, trap,
           int_val1, int_val2, fp_val1, fp_val2,
    input  stall
  );

  modport slave (
    input  valid, op, pc, insn, csr_addr, src1, src2, dst,
           rd_int1, rd_int2, rd_fp1, rd_fp2, wr_int, wr_fp, trap,
           int_val1, int_val2, fp_val1, fp_val2,
    output stall
  );
endinterface

// File: rtl/reg_read_stage.sv
// Register-read stage with int/fp busy-bit scoreboard between decode and execute.
// Optional same-cycle writeback forwarding: define RAFI_REGREAD_WB_BYPASS_EN.
module reg_read_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned FLEN   = 64,
  parameter int unsigned OP_W   = 64,
  parameter int unsigned TRAP_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  reg_read_stage_if.slave  prev,
  reg_read_stage_if.master next,
  input  logic             flush,
  output logic [4:0]       int_raddr1,
  output logic [4:0]       int_raddr2,
  input  logic [XLEN-1:0]  int_rdata1,
  input  logic [XLEN-1:0]  int_rdata2,
  output logic [4:0]       fp_raddr1,
  output logic [4:0]       fp_raddr2,
  input  logic [FLEN-1:0]  fp_rdata1,
  input  logic [FLEN-1:0]  fp_rdata2,
  input  logic             wb_int_we,
  input  logic             wb_fp_we,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_int_data,
  input  logic [FLEN-1:0]  wb_fp_data
);

  logic [31:0]     int_busy, fp_busy, int_busy_d, fp_busy_d;
  logic [31:0]     int_pend, fp_pend;
  logic [31:0]     wb_int_hit, wb_fp_hit;
  logic            trap_v, src_busy, dst_busy, hazard, issue;
  logic [XLEN-1:0] int_op1, int_op2;
  logic [FLEN-1:0] fp_op1, fp_op2;
  logic            unused_prev_vals;

  // Decode never supplies operand values; those interface fields are ignored here.
  assign unused_prev_vals = ^{prev.int_val1, prev.int_val2, prev.fp_val1, prev.fp_val2};

  assign int_raddr1 = prev.src1;
  assign int_raddr2 = prev.src2;
  assign fp_raddr1  = prev.src1;
  assign fp_raddr2  = prev.src2;

  assign trap_v = prev.trap[TRAP_W-1];

  always_comb begin
    wb_int_hit = '0;
    wb_fp_hit  = '0;
    if (wb_int_we && (wb_addr != 5'd0)) wb_int_hit[wb_addr] = 1'b1;
    if (wb_fp_we)                       wb_fp_hit[wb_addr]  = 1'b1;
  end

`ifdef RAFI_REGREAD_WB_BYPASS_EN
  assign int_pend = int_busy & ~wb_int_hit;
  assign fp_pend  = fp_busy & ~wb_fp_hit;
`else
  assign int_pend = int_busy;
  assign fp_pend  = fp_busy;
`endif

  // Only sources see the writeback; WAW on the destination always uses the registered busy bits.
  assign src_busy = (prev.rd_int1 & int_pend[prev.src1]) | (prev.rd_int2 & int_pend[prev.src2]) |
                    (prev.rd_fp1  & fp_pend[prev.src1])  | (prev.rd_fp2  & fp_pend[prev.src2]);
  assign dst_busy = (prev.wr_int & int_busy[prev.dst]) | (prev.wr_fp & fp_busy[prev.dst]);
  assign hazard   = prev.valid & ~trap_v & (src_busy | dst_busy);
  assign issue    = prev.valid & ~hazard & ~next.stall & ~flush;

  assign prev.stall = ~rst & prev.valid & ~flush & (hazard | next.stall);

  always_comb begin
    int_op1 = int_rdata1;
    int_op2 = int_rdata2;
    fp_op1  = fp_rdata1;
    fp_op2  = fp_rdata2;
`ifdef RAFI_REGREAD_WB_BYPASS_EN
    if (wb_int_hit[prev.src1]) int_op1 = wb_int_data;
    if (wb_int_hit[prev.src2]) int_op2 = wb_int_data;
    if (wb_fp_hit[prev.src1])  fp_op1  = wb_fp_data;
    if (wb_fp_hit[prev.src2])  fp_op2  = wb_fp_data;
`endif
    if (trap_v) begin
      int_op1 = '0;
      int_op2 = '0;
      fp_op1  = '0;
      fp_op2  = '0;
    end
  end

  // Set is applied after clear so a same-cycle clear/set of one bit leaves it busy.
  always_comb begin
    int_busy_d = int_busy;
    fp_busy_d  = fp_busy;
    if (wb_int_we) int_busy_d[wb_addr] = 1'b0;
    if (wb_fp_we)  fp_busy_d[wb_addr]  = 1'b0;
    if (issue && !trap_v && prev.wr_int) int_busy_d[prev.dst] = 1'b1;
    if (issue && !trap_v && prev.wr_fp)  fp_busy_d[prev.dst]  = 1'b1;
    int_busy_d[0] = 1'b0;
    if (flush) begin
      int_busy_d = '0;
      fp_busy_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_busy <= '0;
      fp_busy  <= '0;
    end else begin
      int_busy <= int_busy_d;
      fp_busy  <= fp_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next.valid    <= 1'b0;
      next.op       <= '0;
      next.pc       <= '0;
      next.insn     <= '0;
      next.csr_addr <= '0;
      next.src1     <= '0;
      next.src2     <= '0;
      next.dst      <= '0;
      next.rd_int1  <= 1'b0;
      next.rd_int2  <= 1'b0;
      next.rd_fp1   <= 1'b0;
      next.rd_fp2   <= 1'b0;
      next.wr_int   <= 1'b0;
      next.wr_fp    <= 1'b0;
      next.trap     <= '0;
      next.int_val1 <= '0;
      next.int_val2 <= '0;
      next.fp_val1  <= '0;
      next.fp_val2  <= '0;
    end else if (flush) begin
      next.valid <= 1'b0;
    end else if (issue) begin
      next.valid    <= 1'b1;
      next.op       <= prev.op;
      next.pc       <= prev.pc;
      next.insn     <= prev.insn;
      next.csr_addr <= prev.csr_addr;
      next.src1     <= prev.src1;
      next.src2     <= prev.src2;
      next.dst      <= prev.dst;
      next.rd_int1  <= prev.rd_int1;
      next.rd_int2  <= prev.rd_int2;
      next.rd_fp1   <= prev.rd_fp1;
      next.rd_fp2   <= prev.rd_fp2;
      next.wr_int   <= prev.wr_int;
      next.wr_fp    <= prev.wr_fp;
      next.trap     <= prev.trap;
      next.int_val1 <= int_op1;
      next.int_val2 <= int_op2;
      next.fp_val1  <= fp_op1;
      next.fp_val2  <= fp_op2;
    end else if (!next.stall) begin
      next.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Scoreboard bench for reg_read_stage: directed ops push expected outputs, a monitor pops on accept.
module tb_reg_read_stage;

  localparam logic [5:0] RI1 = 6'b100000;
  localparam logic [5:0] RI2 = 6'b010000;
  localparam logic [5:0] RF1 = 6'b001000;
  localparam logic [5:0] WI  = 6'b000010;
  localparam logic [5:0] WF  = 6'b000001;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dst;
    logic [39:0] trap;
    logic [3:0]  care;   // {fv2, fv1, iv2, iv1}
    logic [31:0] iv1;
    logic [31:0] iv2;
    logic [63:0] fv1;
    logic [63:0] fv2;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [4:0]  int_raddr1, int_raddr2, fp_raddr1, fp_raddr2;
  logic [31:0] int_rdata1, int_rdata2;
  logic [63:0] fp_rdata1, fp_rdata2;
  logic        wb_int_we, wb_fp_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_int_data;
  logic [63:0] wb_fp_data;

  logic [31:0] int_rf [32];
  logic [63:0] fp_rf  [32];

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   accepted = 0;

  reg_read_stage_if #(.XLEN(32), .FLEN(64), .OP_W(64), .TRAP_W(40)) dec_if ();
  reg_read_stage_if #(.XLEN(32), .FLEN(64), .OP_W(64), .TRAP_W(40)) ex_if ();

  reg_read_stage #(.XLEN(32), .FLEN(64), .OP_W(64), .TRAP_W(40)) dut (
    .clk         (clk),
    .rst         (rst),
    .prev        (dec_if),
    .next        (ex_if),
    .flush       (flush),
    .int_raddr1  (int_raddr1),
    .int_raddr2  (int_raddr2),
    .int_rdata1  (int_rdata1),
    .int_rdata2  (int_rdata2),
    .fp_raddr1   (fp_raddr1),
    .fp_raddr2   (fp_raddr2),
    .fp_rdata1   (fp_rdata1),
    .fp_rdata2   (fp_rdata2),
    .wb_int_we   (wb_int_we),
    .wb_fp_we    (wb_fp_we),
    .wb_addr     (wb_addr),
    .wb_int_data (wb_int_data),
    .wb_fp_data  (wb_fp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register files: x(i)=0x1000+i (x0=0), f(i)=0xF000..00+i; writes land at the clock edge.
  assign int_rdata1 = int_rf[int_raddr1];
  assign int_rdata2 = int_rf[int_raddr2];
  assign fp_rdata1  = fp_rf[fp_raddr1];
  assign fp_rdata2  = fp_rf[fp_raddr2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        int_rf[i] <= (i == 0) ? 32'h0 : 32'h1000 + i;
        fp_rf[i]  <= 64'hF000_0000_0000_0000 | 64'(i);
      end
    end else begin
      if (wb_int_we && wb_addr != 5'd0) int_rf[wb_addr] <= wb_int_data;
      if (wb_fp_we) fp_rf[wb_addr] <= wb_fp_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    #2;
    chk(name, 64'(dec_if.stall), 64'(exp));
  endtask

  task automatic op(input logic [31:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                    input logic [4:0] d, input logic [5:0] f, input logic [39:0] trap);
    dec_if.valid    = 1'b1;
    dec_if.op       = {32'hC0DE_0000, pc};
    dec_if.pc       = pc;
    dec_if.insn     = pc ^ 32'h0000_0013;
    dec_if.csr_addr = pc[11:0];
    dec_if.src1     = s1;
    dec_if.src2     = s2;
    dec_if.dst      = d;
    {dec_if.rd_int1, dec_if.rd_int2, dec_if.rd_fp1, dec_if.rd_fp2, dec_if.wr_int, dec_if.wr_fp} = f;
    dec_if.trap     = trap;
  endtask

  task automatic idle();
    dec_if.valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] d, input logic [39:0] trap,
                      input logic [3:0] care, input logic [31:0] iv1, input logic [31:0] iv2,
                      input logic [63:0] fv1, input logic [63:0] fv2);
    exp_t e;
    e.pc = pc; e.dst = d; e.trap = trap; e.care = care;
    e.iv1 = iv1; e.iv2 = iv2; e.fv1 = fv1; e.fv2 = fv2;
    sb.push_back(e);
  endtask

  task automatic wb_int(input logic [4:0] a, input logic [31:0] data);
    wb_int_we = 1'b1; wb_addr = a; wb_int_data = data;
  endtask

  task automatic wb_fp(input logic [4:0] a, input logic [63:0] data);
    wb_fp_we = 1'b1; wb_addr = a; wb_fp_data = data;
  endtask

  task automatic wb_off();
    wb_int_we = 1'b0; wb_fp_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && ex_if.valid && !ex_if.stall) begin
      accepted++;
      if (sb.size() == 0) begin
        chk("unexpected_out_pc", 64'(ex_if.pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_pc",   64'(ex_if.pc),   64'(e.pc));
        chk("out_dst",  64'(ex_if.dst),  64'(e.dst));
        chk("out_trap", 64'(ex_if.trap), 64'(e.trap));
        if (e.care[0]) chk("out_iv1", 64'(ex_if.int_val1), 64'(e.iv1));
        if (e.care[1]) chk("out_iv2", 64'(ex_if.int_val2), 64'(e.iv2));
        if (e.care[2]) chk("out_fv1", ex_if.fp_val1, e.fv1);
        if (e.care[3]) chk("out_fv2", ex_if.fp_val2, e.fv2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc0;
    rst = 1'b1; flush = 1'b0; ex_if.stall = 1'b1;
    wb_int_we = 1'b0; wb_fp_we = 1'b0; wb_addr = '0; wb_int_data = '0; wb_fp_data = '0;
    dec_if.int_val1 = '0; dec_if.int_val2 = '0; dec_if.fp_val1 = '0; dec_if.fp_val2 = '0;
    op(32'hBAD, 5'd1, 5'd2, 5'd1, RI1 | WI, 40'h0);

    // Reset: valid op and downstream stall present, yet nothing issues and stall_out stays low.
    repeat (2) tick();
    chk_stall("rst_stall", 1'b0);
    chk("rst_valid", 64'(ex_if.valid), 64'd0);
    chk("rst_pc", 64'(ex_if.pc), 64'd0);
    chk("rst_busy", 64'(dut.int_busy), 64'd0);
    rst = 1'b0; ex_if.stall = 1'b0; idle();
    tick();

    // Independent stream of three ops.
    acc0 = accepted;
    op(32'h100, 5'd1, 5'd2, 5'd10, RI1 | RI2, 40'h0);
    push(32'h100, 5'd10, 40'h0, 4'b0011, 32'h1001, 32'h1002, 64'h0, 64'h0);
    chk_stall("ind_stall0", 1'b0);
    tick();
    op(32'h104, 5'd3, 5'd4, 5'd11, RI1 | RI2, 40'h0);
    push(32'h104, 5'd11, 40'h0, 4'b0011, 32'h1003, 32'h1004, 64'h0, 64'h0);
    chk_stall("ind_stall1", 1'b0);
    tick();
    op(32'h108, 5'd1, 5'd3, 5'd12, RI1 | RI2, 40'h0);
    push(32'h108, 5'd12, 40'h0, 4'b0011, 32'h1001, 32'h1003, 64'h0, 64'h0);
    chk_stall("ind_stall2", 1'b0);
    tick();
    idle();
    chk("ind_acc2", 64'(accepted - acc0), 64'd2);
    tick();
    chk("ind_acc3", 64'(accepted - acc0), 64'd3);
    chk("ind_bubble", 64'(ex_if.valid), 64'd0);

    // RAW on x5 resolved by writeback of 0xDEADBEEF.
    op(32'h200, 5'd1, 5'd2, 5'd5, RI1 | RI2 | WI, 40'h0);
    push(32'h200, 5'd5, 40'h0, 4'b0011, 32'h1001, 32'h1002, 64'h0, 64'h0);
    chk_stall("raw_a", 1'b0);
    tick();
    op(32'h204, 5'd5, 5'd0, 5'd6, RI1 | RI2 | WI, 40'h0);
    chk_stall("raw_b1", 1'b1);
    tick();
    chk_stall("raw_b2", 1'b1);
    tick();
    chk_stall("raw_b3", 1'b1);
    tick();
    wb_int(5'd5, 32'hDEAD_BEEF);
`ifdef RAFI_REGREAD_WB_BYPASS_EN
    push(32'h204, 5'd6, 40'h0, 4'b0011, 32'hDEAD_BEEF, 32'h0, 64'h0, 64'h0);
    chk_stall("raw_wb", 1'b0);
    tick();
    wb_off(); idle();
`else
    chk_stall("raw_wb", 1'b1);
    tick();
    wb_off();
    push(32'h204, 5'd6, 40'h0, 4'b0011, 32'hDEAD_BEEF, 32'h0, 64'h0, 64'h0);
    chk_stall("raw_issue", 1'b0);
    tick();
    idle();
`endif
    tick();
    wb_int(5'd6, 32'h66);
    tick();
    wb_off();

    // x0 destination never becomes busy.
    op(32'h300, 5'd1, 5'd0, 5'd0, RI1 | WI, 40'h0);
    push(32'h300, 5'd0, 40'h0, 4'b0001, 32'h1001, 32'h0, 64'h0, 64'h0);
    chk_stall("x0_a", 1'b0);
    tick();
    op(32'h304, 5'd0, 5'd0, 5'd12, RI1 | RI2, 40'h0);
    push(32'h304, 5'd12, 40'h0, 4'b0011, 32'h0, 32'h0, 64'h0, 64'h0);
    chk_stall("x0_b", 1'b0);
    tick();
    idle();
    chk("x0_busy", 64'(dut.int_busy[0]), 64'd0);
    tick();

    // Downstream stall holds the output register for three cycles.
    op(32'h400, 5'd1, 5'd2, 5'd8, RI1 | RI2 | WI, 40'h0);
    push(32'h400, 5'd8, 40'h0, 4'b0011, 32'h1001, 32'h1002, 64'h0, 64'h0);
    chk_stall("ns_e", 1'b0);
    tick();
    ex_if.stall = 1'b1;
    op(32'h404, 5'd3, 5'd4, 5'd9, RI1 | RI2 | WI, 40'h0);
    for (int i = 0; i < 3; i++) begin
      chk_stall("ns_stall", 1'b1);
      chk("ns_pc_frozen", 64'(ex_if.pc), 64'h400);
      chk("ns_valid_held", 64'(ex_if.valid), 64'd1);
      chk("ns_busy9", 64'(dut.int_busy[9]), 64'd0);
      tick();
    end
    ex_if.stall = 1'b0;
    push(32'h404, 5'd9, 40'h0, 4'b0011, 32'h1003, 32'h1004, 64'h0, 64'h0);
    chk_stall("ns_release", 1'b0);
    tick();
    idle();
    chk("ns_busy8", 64'(dut.int_busy[8]), 64'd1);
    chk("ns_busy9_set", 64'(dut.int_busy[9]), 64'd1);
    wb_int(5'd8, 32'h88);
    tick();
    wb_int(5'd9, 32'h99);
    tick();
    wb_off();
    chk("ns_busy_clr", 64'(dut.int_busy), 64'd0);

    // Flush with f3 busy, G held downstream and H stalled behind f3.
    op(32'h500, 5'd1, 5'd0, 5'd3, RI1 | WF, 40'h0);
    chk_stall("fl_g", 1'b0);
    tick();
    ex_if.stall = 1'b1;
    op(32'h504, 5'd3, 5'd0, 5'd4, RF1 | WF, 40'h0);
    chk_stall("fl_b1", 1'b1);
    tick();
    chk_stall("fl_b2", 1'b1);
    tick();
    flush = 1'b1;
    chk_stall("fl_flush", 1'b0);
    tick();
    flush = 1'b0; ex_if.stall = 1'b0;
    chk("fl_valid", 64'(ex_if.valid), 64'd0);
    chk("fl_fpbusy", 64'(dut.fp_busy), 64'd0);
    push(32'h504, 5'd4, 40'h0, 4'b0100, 32'h0, 32'h0, 64'hF000_0000_0000_0003, 64'h0);
    chk_stall("fl_after", 1'b0);
    tick();
    idle();
    tick();
    wb_fp(5'd4, 64'h4444);
    tick();
    wb_off();

    // Stale writeback of x7 coincides with a new op setting x7: set wins.
    op(32'h600, 5'd1, 5'd2, 5'd7, RI1 | RI2 | WI, 40'h0);
    wb_int(5'd7, 32'h7777);
    push(32'h600, 5'd7, 40'h0, 4'b0011, 32'h1001, 32'h1002, 64'h0, 64'h0);
    chk_stall("sim_issue", 1'b0);
    tick();
    wb_off(); idle();
    chk("sim_busy7", 64'(dut.int_busy[7]), 64'd1);

    // Trap op ignores busy x7, sets no busy bit and carries zero operands.
    op(32'h700, 5'd7, 5'd0, 5'd12, RI1 | WI, 40'h82_0000_0700);
    push(32'h700, 5'd12, 40'h82_0000_0700, 4'b0001, 32'h0, 32'h0, 64'h0, 64'h0);
    chk_stall("trap_nostall", 1'b0);
    tick();
    idle();
    chk("trap_busy12", 64'(dut.int_busy[12]), 64'd0);

    // Reader of x7 waits for its real writeback.
    op(32'h800, 5'd7, 5'd0, 5'd13, RI1, 40'h0);
    chk_stall("k_stall", 1'b1);
    tick();
    wb_int(5'd7, 32'h7A7A);
`ifdef RAFI_REGREAD_WB_BYPASS_EN
    push(32'h800, 5'd13, 40'h0, 4'b0001, 32'h7A7A, 32'h0, 64'h0, 64'h0);
    chk_stall("k_wb", 1'b0);
    tick();
    wb_off(); idle();
`else
    chk_stall("k_wb", 1'b1);
    tick();
    wb_off();
    push(32'h800, 5'd13, 40'h0, 4'b0001, 32'h7A7A, 32'h0, 64'h0, 64'h0);
    chk_stall("k_issue", 1'b0);
    tick();
    idle();
`endif
    repeat (2) tick();

    chk("drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
